mram_timing_seq: RTL and testbench

//  Sits between the AXI MRAM slave controller's MRAM port and the MRAM macro. Sequences

---
 rtl/mram_pkg.sv | 30 +++
 rtl/mram_rd_pipe.sv | 91 +++++++++
 rtl/mram_timing_seq.sv | 163 ++++++++++++++++
 tb/tb_mram_timing_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mram_pkg.sv
// -----------------------------------------------------------------------------
// mram_pkg
//   Shared types and constants for the MRAM timing sequencer.
//   - mram_seq_state_t : sequencer FSM states
//   - ERR_*            : bit positions inside err_flags
//   - CNT_W            : width of the write-pulse / power-up counter
//   - pulse_len()      : maps a programmed write delay to its pulse length
// -----------------------------------------------------------------------------
package mram_pkg;

    typedef enum logic [1:0] {
        PWR_OFF,
        PWR_UP,
        IDLE,
        WRITE
    } mram_seq_state_t;

    localparam int ERR_COLLIDE = 0;  // we and re in the same accepted cycle
    localparam int ERR_OOR     = 1;  // byte address beyond the macro depth
    localparam int ERR_ABORT   = 2;  // supply lost while a write pulse was active
    localparam int ERR_W       = 3;

    localparam int CNT_W = 14;

    // A programmed delay of zero still produces a single-cycle pulse.
    function automatic logic [CNT_W-1:0] pulse_len(input logic [CNT_W-1:0] cfg);
        return (cfg == '0) ? CNT_W'(1) : cfg;
    endfunction

endpackage

// File: rtl/mram_rd_pipe.sv
// -----------------------------------------------------------------------------
// mram_rd_pipe
//   Read-return pipeline between the MRAM macro output and ctrl_rdata.
//   STAGES valid/zero flags track each issued read; the macro data itself is
//   delayed by STAGES-1 registers because it only becomes valid one cycle after
//   the read strobe. rdata is registered and holds between returns.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     flush       drop every read in flight and block the output update
//     in_valid    a read was issued to the macro last edge
//     in_zero     that read was out of range and must return zero
//     mac_dout    macro read data
//     rdata       returned read data
// -----------------------------------------------------------------------------
module mram_rd_pipe
    import mram_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] mac_dout,
    output logic [DATA_W-1:0] rdata
);

    localparam int DLY = (STAGES > 0) ? STAGES - 1 : 0;

    logic              out_vld;
    logic              out_zero;
    logic [DATA_W-1:0] src;

    if (STAGES == 0) begin : g_no_stage
        assign out_vld  = in_valid;
        assign out_zero = in_zero;
    end else begin : g_stage
        logic [STAGES-1:0] vld;
        logic [STAGES-1:0] zer;

        // NOTE: sequential state is assigned with <= so every stage samples the
        // pre-edge value of its neighbour; blocking here would collapse the shift.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld <= '0;
                zer <= '0;
            end else if (flush) begin
                vld <= '0;
                zer <= '0;
            end else begin
                vld[0] <= in_valid;
                zer[0] <= in_zero;
                for (int i = 1; i < STAGES; i++) begin
                    vld[i] <= vld[i-1];
                    zer[i] <= zer[i-1];
                end
            end
        end

        assign out_vld  = vld[STAGES-1];
        assign out_zero = zer[STAGES-1];
    end

    if (DLY == 0) begin : g_no_dly
        assign src = mac_dout;
    end else begin : g_dly
        logic [DATA_W-1:0] dly [DLY];

        // NOTE: the data delay line has no reset; its contents are only used
        // when a valid flag arrives alongside, so reset would cost flops for nothing.
        always_ff @(posedge clk) begin
            dly[0] <= mac_dout;
            for (int i = 1; i < DLY; i++) begin
                dly[i] <= dly[i-1];
            end
        end

        assign src = dly[DLY-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (!flush && out_vld) begin
            rdata <= out_zero ? '0 : src;
        end
    end

endmodule

// File: rtl/mram_timing_seq.sv
// -----------------------------------------------------------------------------
// mram_timing_seq
//   Timing sequencer between the AXI MRAM controller port and the MRAM macro.
//   Handles supply power-up delay, byte-to-word address conversion, holds the
//   controller off for the programmed write-pulse length and returns read data
//   a fixed MRAM_READ_LAT edges after the read is accepted.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     pwr_on            macro supply good
//     write_delay_cfg   write pulse length in cycles (0 behaves as 1)
//     ctrl_*            controller side: addr/wdata/we/re/cs in, rdata/ready out
//     mac_*             macro side: ce/we/re/addr/din out, dout in
//     err_flags         sticky errors: collision, out-of-range, power abort
// -----------------------------------------------------------------------------
module mram_timing_seq
    import mram_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 64,
    parameter int MAC_AW        = 14,
    parameter int MRAM_READ_LAT = 2,
    parameter int PWRUP_CYCLES  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwr_on,
    input  logic [CNT_W-1:0]  write_delay_cfg,
    input  logic [ADDR_W-1:0] ctrl_addr,
    input  logic [DATA_W-1:0] ctrl_wdata,
    input  logic              ctrl_we,
    input  logic              ctrl_re,
    input  logic              ctrl_cs,
    output logic [DATA_W-1:0] ctrl_rdata,
    output logic              ctrl_ready,
    output logic              mac_ce,
    output logic              mac_we,
    output logic              mac_re,
    output logic [MAC_AW-1:0] mac_addr,
    output logic [DATA_W-1:0] mac_din,
    input  logic [DATA_W-1:0] mac_dout,
    output logic [ERR_W-1:0]  err_flags
);

    localparam int BYTE_SH = $clog2(DATA_W / 8);

    mram_seq_state_t   state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  wr_len;
    logic              rd_issue;
    logic              rd_zero;
    logic [ADDR_W-1:0] word_addr;
    logic              oor;

    assign word_addr  = ctrl_addr >> BYTE_SH;
    assign oor        = |(word_addr >> MAC_AW);
    assign ctrl_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PWR_OFF;
            cnt       <= '0;
            wr_len    <= '0;
            mac_ce    <= 1'b0;
            mac_we    <= 1'b0;
            mac_re    <= 1'b0;
            mac_addr  <= '0;
            mac_din   <= '0;
            rd_issue  <= 1'b0;
            rd_zero   <= 1'b0;
            err_flags <= '0;
        end else begin
            // Read strobe and issue marker are single-cycle pulses.
            mac_re   <= 1'b0;
            rd_issue <= 1'b0;
            rd_zero  <= 1'b0;

            if (!pwr_on) begin
                // Supply loss overrides everything, including a pulse in progress.
                if (state == WRITE) begin
                    err_flags[ERR_ABORT] <= 1'b1;
                end
                state  <= PWR_OFF;
                cnt    <= '0;
                mac_ce <= 1'b0;
                mac_we <= 1'b0;
            end else begin
                case (state)
                    PWR_OFF: begin
                        state <= PWR_UP;
                        cnt   <= '0;
                    end

                    PWR_UP: begin
                        if (cnt == CNT_W'(PWRUP_CYCLES - 1)) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    IDLE: begin
                        mac_ce <= 1'b0;
                        mac_we <= 1'b0;
                        if (ctrl_cs && (ctrl_we || ctrl_re) && oor) begin
                            err_flags[ERR_OOR] <= 1'b1;
                        end
                        if (ctrl_cs && ctrl_re) begin
                            // Read wins a we/re collision. Out-of-range reads skip
                            // the macro but still return zero on schedule.
                            if (ctrl_we) begin
                                err_flags[ERR_COLLIDE] <= 1'b1;
                            end
                            mac_re   <= !oor;
                            mac_ce   <= !oor;
                            mac_addr <= word_addr[MAC_AW-1:0];
                            rd_issue <= 1'b1;
                            rd_zero  <= oor;
                        end else if (ctrl_cs && ctrl_we && !oor) begin
                            // Pulse length is frozen here; cfg changes mid-pulse are ignored.
                            state    <= WRITE;
                            cnt      <= CNT_W'(1);
                            wr_len   <= pulse_len(write_delay_cfg);
                            mac_ce   <= 1'b1;
                            mac_we   <= 1'b1;
                            mac_addr <= word_addr[MAC_AW-1:0];
                            mac_din  <= ctrl_wdata;
                        end
                    end

                    WRITE: begin
                        if (cnt == wr_len) begin
                            state  <= IDLE;
                            cnt    <= '0;
                            mac_ce <= 1'b0;
                            mac_we <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    default: state <= PWR_OFF;
                endcase
            end
        end
    end

    // The return pipe runs independently of the FSM so reads in flight finish
    // even after a write has been accepted; only supply loss flushes it.
    mram_rd_pipe #(
        .DATA_W (DATA_W),
        .STAGES (MRAM_READ_LAT - 1)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (!pwr_on),
        .in_valid (rd_issue),
        .in_zero  (rd_zero),
        .mac_dout (mac_dout),
        .rdata    (ctrl_rdata)
    );

endmodule

// File: tb/tb_mram_timing_seq.sv
// -----------------------------------------------------------------------------
// tb_mram_timing_seq
//   Self-checking bench for mram_timing_seq. A behavioural macro model answers
//   mac_re with stored data (random junk otherwise). A transaction-level
//   reference model tracks, per clock edge, when ready is expected, which edges
//   carry a write pulse or read strobe, and which edge each read returns on.
// -----------------------------------------------------------------------------
module tb_mram_timing_seq;

    localparam int LAT   = 2;
    localparam int PWRUP = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwr_on;
    logic [13:0] write_delay_cfg;
    logic [31:0] ctrl_addr;
    logic [63:0] ctrl_wdata;
    logic        ctrl_we;
    logic        ctrl_re;
    logic        ctrl_cs;
    logic [63:0] ctrl_rdata;
    logic        ctrl_ready;
    logic        mac_ce;
    logic        mac_we;
    logic        mac_re;
    logic [13:0] mac_addr;
    logic [63:0] mac_din;
    logic [63:0] mac_dout = '0;
    logic [2:0]  err_flags;

    always #5 clk = ~clk;

    mram_timing_seq dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pwr_on          (pwr_on),
        .write_delay_cfg (write_delay_cfg),
        .ctrl_addr       (ctrl_addr),
        .ctrl_wdata      (ctrl_wdata),
        .ctrl_we         (ctrl_we),
        .ctrl_re         (ctrl_re),
        .ctrl_cs         (ctrl_cs),
        .ctrl_rdata      (ctrl_rdata),
        .ctrl_ready      (ctrl_ready),
        .mac_ce          (mac_ce),
        .mac_we          (mac_we),
        .mac_re          (mac_re),
        .mac_addr        (mac_addr),
        .mac_din         (mac_din),
        .mac_dout        (mac_dout),
        .err_flags       (err_flags)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] init_pat(input int w);
        return {8'hA5, 24'(w), 32'(~w)};
    endfunction

    // Behavioural macro: one-cycle read latency, junk on dout when not reading.
    logic [63:0] mac_mem [int];
    always @(posedge clk) begin
        if (mac_ce && mac_we) mac_mem[int'(mac_addr)] = mac_din;
        if (mac_ce && mac_re)
            mac_dout <= mac_mem.exists(int'(mac_addr)) ? mac_mem[int'(mac_addr)]
                                                       : init_pat(int'(mac_addr));
        else
            mac_dout <= {$urandom, $urandom};
    end

    // Reference model state, indexed by clock-edge number.
    typedef struct {
        int          at;
        logic [63:0] data;
    } ret_t;

    logic [63:0] ref_mem [int];
    bit          m_on       = 1'b0;
    int          ready_from = 0;
    int          wr_start   = 0;
    int          wr_end     = 0;
    logic [13:0] wr_addr    = '0;
    logic [63:0] wr_data    = '0;
    bit          re_exp  [int];
    logic [13:0] re_addr [int];
    ret_t        ret_q [$];
    logic [63:0] exp_rdata = '0;
    logic [2:0]  exp_err   = '0;

    function automatic logic [63:0] mem_val(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : init_pat(w);
    endfunction

    // One clock: drive inputs, predict, advance one edge, compare outputs.
    task automatic step(input bit pwr, input bit cs, input bit we, input bit re,
                        input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [13:0] cfg);
        int   c;
        int   k;
        bit   rdy;
        int   w;
        bit   oor;
        int   len;
        bit   we_on;
        bit   re_on;
        ret_t r;
        c   = cyc;
        k   = cyc + 1;
        rdy = m_on && (c >= ready_from);
        w   = int'(addr >> 3);
        oor = (addr >> 3) >= 32'd16384;

        pwr_on          = pwr;
        ctrl_cs         = cs;
        ctrl_we         = we;
        ctrl_re         = re;
        ctrl_addr       = addr;
        ctrl_wdata      = wdata;
        write_delay_cfg = cfg;

        if (!pwr) begin
            if (m_on && c >= wr_start && c < wr_end) exp_err[2] = 1'b1;
            if (wr_end > k) wr_end = k;
            while (ret_q.size() > 0 && ret_q[$].at >= k) void'(ret_q.pop_back());
            m_on = 1'b0;
        end else if (!m_on) begin
            m_on       = 1'b1;
            ready_from = k + PWRUP;
        end else if (rdy && cs && (we || re)) begin
            if (oor) exp_err[1] = 1'b1;
            if (we && re) exp_err[0] = 1'b1;
            if (re) begin
                if (!oor) begin
                    re_exp[k]  = 1'b1;
                    re_addr[k] = 14'(w);
                end
                r.at   = k + LAT;
                r.data = oor ? 64'd0 : mem_val(w);
                ret_q.push_back(r);
            end else if (!oor) begin
                len        = (cfg == 14'd0) ? 1 : int'(cfg);
                wr_start   = k;
                wr_end     = k + len;
                wr_addr    = 14'(w);
                wr_data    = wdata;
                ready_from = k + len;
                ref_mem[w] = wdata;
            end
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);

        if (ret_q.size() > 0 && ret_q[0].at == cyc) begin
            r         = ret_q.pop_front();
            exp_rdata = r.data;
        end
        we_on = (cyc >= wr_start) && (cyc < wr_end);
        re_on = re_exp.exists(cyc);
        check("ready",  ctrl_ready, m_on && (cyc >= ready_from));
        check("mac_we", mac_we, we_on);
        check("mac_re", mac_re, re_on);
        check("mac_ce", mac_ce, we_on || re_on);
        if (we_on) begin
            check("wr_addr", mac_addr, wr_addr);
            check("wr_din",  mac_din,  wr_data);
        end
        if (re_on) check("rd_addr", mac_addr, re_addr[cyc]);
        check("rdata", ctrl_rdata, exp_rdata);
        check("err",   err_flags,  exp_err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic rd(input logic [31:0] addr);
        step(1'b1, 1'b1, 1'b0, 1'b1, addr, {$urandom, $urandom}, '0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [63:0] data, input logic [13:0] cfg);
        step(1'b1, 1'b1, 1'b1, 1'b0, addr, data, cfg);
    endtask

    initial begin
        bit          pwr;
        bit          cs;
        int          op;
        logic [31:0] addr;

        rst_n           = 1'b0;
        pwr_on          = 1'b0;
        ctrl_cs         = 1'b0;
        ctrl_we         = 1'b0;
        ctrl_re         = 1'b0;
        ctrl_addr       = '0;
        ctrl_wdata      = '0;
        write_delay_cfg = '0;
        repeat (3) @(negedge clk);

        check("rst_ready", ctrl_ready, 1'b0);
        check("rst_ce",    mac_ce,     1'b0);
        check("rst_we",    mac_we,     1'b0);
        check("rst_re",    mac_re,     1'b0);
        check("rst_addr",  mac_addr,   14'd0);
        check("rst_din",   mac_din,    64'd0);
        check("rst_rdata", ctrl_rdata, 64'd0);
        check("rst_err",   err_flags,  3'd0);
        rst_n = 1'b1;

        // Unpowered: requests are ignored.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, '0, '0);

        // Power-up delay, then directed read latency at byte 0x40 (word 8).
        idle(PWRUP + 4);
        rd(32'h40);
        idle(3);

        // Back-to-back burst of 16 reads.
        for (int i = 0; i < 16; i++) rd(32'h100 + 32'(i * 8));
        idle(4);

        // Write pulse lengths 5 and 0 (treated as 1), then read back.
        wr(32'h80, 64'h1122_3344_5566_7788, 14'd5);
        idle(6);
        rd(32'h80);
        wr(32'h88, 64'hDEAD_BEEF_0BAD_F00D, 14'd0);
        idle(2);
        rd(32'h88);
        idle(3);

        // Collision, out-of-range read/write, top in-range word.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 64'hFFFF_0000_FFFF_0000, 14'd3);
        idle(3);
        rd(32'h0002_0000);
        idle(3);
        wr(32'h0002_0000, 64'h0123_4567_89AB_CDEF, 14'd2);
        idle(3);
        rd(32'h0001_FFF8);
        idle(3);

        // Supply loss at the third cycle of a 10-cycle write, then re-power.
        wr(32'h90, 64'hCAFE_CAFE_CAFE_CAFE, 14'd10);
        idle(2);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        idle(PWRUP + 3);
        rd(32'h90);
        idle(3);

        // Randomized traffic with occasional supply drops.
        for (int i = 0; i < 500; i++) begin
            pwr = ($urandom_range(0, 99) != 0);
            cs  = ($urandom_range(0, 7) != 0);
            op  = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0)
                addr = 32'h0002_0000 | ($urandom & 32'h0FFF_FFFF);
            else
                addr = (32'($urandom_range(0, 31)) << 3) | 32'($urandom_range(0, 7));
            step(pwr, cs, (op == 2) || (op == 3), (op == 1) || (op == 3), addr,
                 {$urandom, $urandom}, 14'($urandom_range(0, 6)));
        end
        idle(PWRUP + 8);

        // Reset in the middle of a write pulse drops the strobes immediately.
        wr(32'h98, 64'h5555_AAAA_5555_AAAA, 14'd10);
        idle(3);
        check("pre_rst_we", mac_we, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we",    mac_we,     1'b0);
        check("arst_ce",    mac_ce,     1'b0);
        check("arst_ready", ctrl_ready, 1'b0);
        check("arst_err",   err_flags,  3'd0);
        check("arst_rdata", ctrl_rdata, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
